// File: rtl/ag6502_bus_pkg.sv
// ag6502_bus_pkg: shared owner codes and state encodings for the ag6502 bus scheduler
package ag6502_bus_pkg;
    localparam logic [1:0] OWN_CPU  = 2'd0;
    localparam logic [1:0] OWN_DMA  = 2'd1;
    localparam logic [1:0] OWN_EXT  = 2'd2;
    localparam logic [1:0] OWN_IDLE = 2'd3;
    typedef enum logic [1:0] {ST_PH1, ST_PH2, ST_WAIT} state_t;
    typedef enum logic [1:0] {ARB_CPU, ARB_HOLD, ARB_EXT} arb_t;
endpackage

// File: rtl/ag6502_bus_sched_arb.sv
// ag6502_bus_sched_arb: hands the phi_0-high slots between the CPU and an external master
// Ports: baseclk/rst clock and sync reset; cycle_end marks the last tick of a CPU cycle;
// cpu_read is the read strobe of the cycle ending; ext_req requests the bus;
// cpu_rdy stalls the CPU; ext_gnt gives the external master the phi_0-high slots.
module ag6502_bus_sched_arb
    import ag6502_bus_pkg::*;
(
    input  logic baseclk,
    input  logic rst,
    input  logic cycle_end,
    input  logic cpu_read,
    input  logic ext_req,
    output logic cpu_rdy,
    output logic ext_gnt
);
    arb_t state, nxt;
    always_ff @(posedge baseclk) begin
        if (rst) state <= ARB_CPU;
        else     state <= nxt;
    end
    // The grant waits for a read cycle end because the CPU ignores RDY while writing.
    always_comb begin
        nxt = state;
        if (cycle_end)
            nxt = !ext_req                         ? ARB_CPU  :
                  (state == ARB_CPU)               ? ARB_HOLD :
                  (state == ARB_HOLD && cpu_read)  ? ARB_EXT  : state;
    end
    always_comb begin
        cpu_rdy = state == ARB_CPU;
        ext_gnt = state == ARB_EXT;
    end
endmodule

// File: rtl/ag6502_bus_sched.sv
// ag6502_bus_sched: derives phi_0 and time-multiplexes the memory bus between DMA, CPU and an external master
// Ports: baseclk/rst clock and sync reset; phi_0 CPU phase clock; cpu_ab/cpu_read/cpu_rdy CPU side;
// dma_req/dma_ab/dma_ack DMA read slot in phi_0-low; ext_req/ext_ab/ext_we/ext_gnt external master;
// mem_wait stretches phi_0-high; mem_ab/mem_cs/mem_we/mem_owner registered memory bus.
module ag6502_bus_sched
    import ag6502_bus_pkg::*;
#(
    parameter int HALF     = 5,
    parameter int MAX_WAIT = 7,
    parameter int AW       = 16
) (
    input  logic          baseclk,
    input  logic          rst,
    output logic          phi_0,
    input  logic [AW-1:0] cpu_ab,
    input  logic          cpu_read,
    output logic          cpu_rdy,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_ab,
    output logic          dma_ack,
    input  logic          ext_req,
    input  logic [AW-1:0] ext_ab,
    input  logic          ext_we,
    output logic          ext_gnt,
    input  logic          mem_wait,
    output logic [AW-1:0] mem_ab,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [1:0]    mem_owner
);
    localparam int CW = $clog2(HALF);
    localparam int WW = $clog2(MAX_WAIT + 2);

    state_t         state, nxt_state;
    logic [CW-1:0]  cnt, nxt_cnt;
    logic [WW-1:0]  wcnt, nxt_wcnt;
    logic           last, cycle_end, enter_ph2;
    logic [AW-1:0]  n_ab;
    logic           n_cs, n_we, n_ack;
    logic [1:0]     n_own;

    always_ff @(posedge baseclk) begin
        if (rst) begin
            state <= ST_PH1;
            cnt   <= '0;
            wcnt  <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            wcnt  <= nxt_wcnt;
        end
    end

    always_comb begin
        last      = cnt == CW'(HALF - 1);
        nxt_state = state;
        nxt_cnt   = last ? '0 : cnt + 1'b1;
        nxt_wcnt  = '0;
        if (state == ST_PH1) begin
            nxt_state = last ? ST_PH2 : ST_PH1;
        end else if (state == ST_PH2) begin
            nxt_state = !last ? ST_PH2 : (mem_wait && MAX_WAIT > 0) ? ST_WAIT : ST_PH1;
            nxt_wcnt  = WW'(nxt_state == ST_WAIT);
        end else begin
            nxt_state = (!mem_wait || wcnt == WW'(MAX_WAIT)) ? ST_PH1 : ST_WAIT;
            nxt_cnt   = '0;
            nxt_wcnt  = (nxt_state == ST_WAIT) ? wcnt + 1'b1 : '0;
        end
    end

    // Bus contents are latched once at each half's entry edge and held for the whole half.
    always_comb begin
        cycle_end = state != ST_PH1 && nxt_state == ST_PH1;
        enter_ph2 = state == ST_PH1 && nxt_state == ST_PH2;
        n_own = cycle_end ? (dma_req ? OWN_DMA : OWN_IDLE) :
                enter_ph2 ? (ext_gnt ? OWN_EXT : OWN_CPU)  : mem_owner;
        n_cs  = cycle_end ? dma_req : enter_ph2 ? 1'b1 : mem_cs;
        n_we  = cycle_end ? 1'b0 : enter_ph2 ? (ext_gnt ? ext_we : !cpu_read) : mem_we;
        n_ab  = cycle_end ? (dma_req ? dma_ab : '0) :
                enter_ph2 ? (ext_gnt ? ext_ab : cpu_ab) : mem_ab;
        n_ack = state == ST_PH1 && nxt_state == ST_PH1 && nxt_cnt == CW'(HALF - 1) && mem_owner == OWN_DMA;
    end

    always_ff @(posedge baseclk) begin
        if (rst) begin
            phi_0     <= 1'b0;
            dma_ack   <= 1'b0;
            mem_ab    <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_owner <= OWN_IDLE;
        end else begin
            phi_0     <= nxt_state != ST_PH1;
            dma_ack   <= n_ack;
            mem_ab    <= n_ab;
            mem_cs    <= n_cs;
            mem_we    <= n_we;
            mem_owner <= n_own;
        end
    end

    ag6502_bus_sched_arb u_arb (
        .baseclk   (baseclk),
        .rst       (rst),
        .cycle_end (cycle_end),
        .cpu_read  (cpu_read),
        .ext_req   (ext_req),
        .cpu_rdy   (cpu_rdy),
        .ext_gnt   (ext_gnt)
    );
endmodule

// File: tb/tb_ag6502_bus_sched.sv
// tb_ag6502_bus_sched: scoreboard bench for ag6502_bus_sched
module tb_ag6502_bus_sched;
    import ag6502_bus_pkg::*;

    logic        baseclk, rst, phi_0, cpu_read, cpu_rdy, dma_req, dma_ack;
    logic        ext_req, ext_we, ext_gnt, mem_wait, mem_cs, mem_we;
    logic [15:0] cpu_ab, dma_ab, ext_ab, mem_ab;
    logic [1:0]  mem_owner;

    ag6502_bus_sched dut (
        .baseclk   (baseclk),
        .rst       (rst),
        .phi_0     (phi_0),
        .cpu_ab    (cpu_ab),
        .cpu_read  (cpu_read),
        .cpu_rdy   (cpu_rdy),
        .dma_req   (dma_req),
        .dma_ab    (dma_ab),
        .dma_ack   (dma_ack),
        .ext_req   (ext_req),
        .ext_ab    (ext_ab),
        .ext_we    (ext_we),
        .ext_gnt   (ext_gnt),
        .mem_wait  (mem_wait),
        .mem_ab    (mem_ab),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_owner (mem_owner)
    );

    initial baseclk = 1'b0;
    always #5 baseclk = ~baseclk;

    typedef struct {
        string       nm;
        logic        p, r, g, a, c, w;
        logic [1:0]  o;
        logic [15:0] ab;
        bit          cb;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    bit          last_dma = 1'b0;
    logic [15:0] last_dab = 16'h0;

    // Monitor: one expected entry per tick, compared shortly after the falling edge.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge baseclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                bad = phi_0 !== e.p || cpu_rdy !== e.r || ext_gnt !== e.g || dma_ack !== e.a ||
                      mem_cs !== e.c || mem_owner !== e.o;
                if (e.cb) bad = bad || mem_ab !== e.ab || mem_we !== e.w;
                if (bad) begin
                    n_bad++;
                    $display("FAIL %s: got phi=%b rdy=%b gnt=%b ack=%b cs=%b we=%b own=%0d ab=%h, expected phi=%b rdy=%b gnt=%b ack=%b cs=%b we=%b own=%0d ab=%h (bus checked=%0d)",
                             e.nm, phi_0, cpu_rdy, ext_gnt, dma_ack, mem_cs, mem_we, mem_owner, mem_ab,
                             e.p, e.r, e.g, e.a, e.c, e.w, e.o, e.ab, e.cb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input string nm, input logic p, r, g, a, c, w,
                        input logic [1:0] o, input logic [15:0] ab, input bit cb);
        exp_t e;
        e.nm = nm; e.p = p; e.r = r; e.g = g; e.a = a; e.c = c; e.w = w;
        e.o = o; e.ab = ab; e.cb = cb;
        q.push_back(e);
        @(negedge baseclk);
    endtask

    task automatic rst_tick(input string nm);
        tick(nm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OWN_IDLE, 16'h0, 1'b1);
    endtask

    // One CPU cycle: PH1 (DMA slot decided by the previous cycle's dma_req), PH2, then ew wait ticks.
    // mem_wait is driven high through PH1 (must be ignored) and for nw ticks from the last PH2 tick.
    task automatic run_cycle(input string nm, input bit dma, input logic [15:0] dab, cab,
                             input bit rd, ext, input logic [15:0] eab, input bit ewe,
                             input int nw, ew, input bit rdy, gnt, input int rst_at);
        bit          ld = last_dma;
        logic [15:0] la = last_dab;
        dma_req = dma; dma_ab = dab; cpu_ab = cab; cpu_read = rd;
        ext_req = ext; ext_ab = eab; ext_we = ewe; mem_wait = 1'b1;
        for (int i = 0; i < 5; i++)
            tick($sformatf("%s.ph1[%0d]", nm, i), 1'b0, rdy, gnt, ld && i == 4, ld, 1'b0,
                 ld ? OWN_DMA : OWN_IDLE, la, ld);
        last_dma = dma;
        last_dab = dab;
        for (int i = 0; i < 5; i++) begin
            mem_wait = (i == 4 && nw > 0);
            tick($sformatf("%s.ph2[%0d]", nm, i), 1'b1, rdy, gnt, 1'b0, 1'b1, gnt ? ewe : !rd,
                 gnt ? OWN_EXT : OWN_CPU, gnt ? eab : cab, 1'b1);
        end
        for (int j = 1; j <= ew; j++) begin
            mem_wait = j < nw;
            if (j == rst_at) rst = 1'b1;
            tick($sformatf("%s.wait[%0d]", nm, j), 1'b1, rdy, gnt, 1'b0, 1'b1, gnt ? ewe : !rd,
                 gnt ? OWN_EXT : OWN_CPU, gnt ? eab : cab, 1'b1);
            if (j == rst_at) begin
                last_dma = 1'b0;
                ext_req  = 1'b0;
                mem_wait = 1'b0;
                rst_tick($sformatf("%s.reset", nm));
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cpu_ab = 16'h0; cpu_read = 1'b1; dma_req = 1'b0; dma_ab = 16'h0;
        ext_req = 1'b0; ext_ab = 16'h0; ext_we = 1'b0; mem_wait = 1'b0;
        @(negedge baseclk);
        rst_tick("reset0");
        rst_tick("reset1");
        rst = 1'b0;
        //        name   dma  dab      cab      rd   ext  eab      ewe  nw  ew  rdy  gnt  rst_at
        run_cycle("C1",  0, 16'h0000, 16'h1234, 1, 0, 16'h0000, 0,  0,  0,  1,   0,   0);
        run_cycle("C2",  1, 16'h0400, 16'h1111, 1, 0, 16'h0000, 0,  0,  0,  1,   0,   0);
        run_cycle("C3",  1, 16'h0400, 16'h2222, 1, 0, 16'h0000, 0,  0,  0,  1,   0,   0);
        run_cycle("C4",  1, 16'h0400, 16'hC0F0, 0, 0, 16'h0000, 0,  3,  3,  1,   0,   0);
        run_cycle("C5",  0, 16'h0400, 16'hC0F0, 0, 0, 16'h0000, 0, 20,  7,  1,   0,   0);
        run_cycle("C6",  0, 16'h0000, 16'h3000, 1, 1, 16'h2000, 1,  0,  0,  1,   0,   0);
        run_cycle("C7",  0, 16'h0000, 16'h3001, 1, 1, 16'h2000, 1,  0,  0,  0,   0,   0);
        run_cycle("C8",  0, 16'h0000, 16'h3002, 1, 1, 16'h2000, 1,  0,  0,  0,   1,   0);
        run_cycle("C9",  0, 16'h0000, 16'h3003, 1, 0, 16'h2000, 1,  0,  0,  0,   1,   0);
        run_cycle("C10", 0, 16'h0000, 16'h4000, 0, 0, 16'h2000, 0,  0,  0,  1,   0,   0);
        run_cycle("C11", 0, 16'h0000, 16'h4001, 0, 1, 16'h2100, 0,  0,  0,  1,   0,   0);
        run_cycle("C12", 0, 16'h0000, 16'h4002, 0, 1, 16'h2100, 0,  0,  0,  0,   0,   0);
        run_cycle("C13", 0, 16'h0000, 16'h4003, 1, 1, 16'h2100, 0,  0,  0,  0,   0,   0);
        run_cycle("C14", 0, 16'h0000, 16'h4004, 1, 0, 16'h2100, 0,  0,  0,  0,   1,   0);
        run_cycle("C15", 0, 16'h0000, 16'h5000, 0, 1, 16'h2200, 0,  0,  0,  1,   0,   0);
        run_cycle("C16", 0, 16'h0000, 16'h5001, 1, 0, 16'h2200, 0,  0,  0,  0,   0,   0);
        run_cycle("C17", 1, 16'h0500, 16'h5002, 1, 1, 16'h2200, 0,  0,  0,  1,   0,   0);
        run_cycle("C18", 1, 16'h0500, 16'h5003, 1, 1, 16'h2200, 0, 20,  7,  0,   0,   3);
        run_cycle("C19", 0, 16'h0000, 16'h6000, 1, 0, 16'h0000, 0,  0,  0,  1,   0,   0);
        run_cycle("C20", 0, 16'h0000, 16'h6001, 1, 0, 16'h0000, 0,  0,  0,  1,   0,   0);
        repeat (3) @(negedge baseclk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
